// File: rtl/drive_ramp_ctrl.sv
// drive_ramp_ctrl: timed drive-command sequencer feeding the dual servo PWM stage.
// Slews both wheel speeds toward per-command targets at a bounded rate, holds
// them for cmd_ms ms, then ramps back to neutral and pulses done.
//
// Ports:
//   Clock, Reset          system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_op [2:0]          0 STOP, 1 FWD, 2 REV, 3 LEFT, 4 RIGHT, 5-7 STOP
//   cmd_ms [15:0]         hold duration in ms ticks
//   abort                 level; forces ramp-down from RAMP or HOLD
//   speed1/speed2 [7:0]   speed codes to the PWM stage (128 = stop)
//   busy                  high whenever not idle
//   done                  one-cycle pulse on return to idle
//   trim1/trim2 [3:0]     signed centre trims, present only with DRIVE_TRIM_EN
//
// Optional feature macro: DRIVE_TRIM_EN
module drive_ramp_ctrl #(
  parameter int unsigned TickDiv    = 50000,
  parameter int unsigned RampPeriod = 2,
  parameter int unsigned RampStep   = 4,
  parameter int unsigned Neutral    = 128,
  parameter int unsigned FwdSpan    = 100,
  parameter int unsigned TurnSpan   = 60
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_ms,
  input  logic        abort,
  output logic [7:0]  speed1,
  output logic [7:0]  speed2,
  output logic        busy,
  output logic        done
`ifdef DRIVE_TRIM_EN
  ,
  input  logic signed [3:0] trim1,
  input  logic signed [3:0] trim2
`endif
);

  localparam int unsigned MsW  = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned RpW  = (RampPeriod > 1) ? $clog2(RampPeriod) : 1;
  localparam int unsigned TgtW = 10;

  localparam logic signed [TgtW-1:0] NeuS = TgtW'(Neutral);
  localparam logic signed [TgtW-1:0] FwdS = TgtW'(FwdSpan);
  localparam logic signed [TgtW-1:0] TrnS = TgtW'(TurnSpan);
  localparam logic [7:0]             Step = 8'(RampStep);
  localparam logic [7:0]             Neu8 = 8'(Neutral);

  typedef enum logic [1:0] {IDLE, RAMP, HOLD, STOPPING} state_t;

`ifndef DRIVE_TRIM_EN
  logic signed [3:0] trim1;
  logic signed [3:0] trim2;
  assign trim1 = 4'sd0;
  assign trim2 = 4'sd0;
`endif

  state_t           state;
  logic [MsW-1:0]   ms_cnt;
  logic [RpW-1:0]   ramp_cnt;
  logic [15:0]      hold_cnt;
  logic [15:0]      ms_q;
  logic [7:0]       t1_q, t2_q, n1_q, n2_q;

  logic             accept;
  logic             ms_tick;
  logic             ramp_tick;
  logic signed [TgtW-1:0] off1, off2, tr1, tr2;
  logic [7:0]       t1_c, t2_c, n1_c, n2_c;

  // Clamp a signed target into the 8-bit speed code range.
  function automatic logic [7:0] sat8(input logic signed [TgtW-1:0] v);
    if (v < 10'sd0)   return 8'd0;
    if (v > 10'sd255) return 8'd255;
    return v[7:0];
  endfunction

  // One bounded ramp step toward tgt, landing exactly on it without overshoot.
  function automatic logic [7:0] step_to(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) return ((tgt - cur) > Step) ? cur + Step : tgt;
    if (cur > tgt) return ((cur - tgt) > Step) ? cur - Step : tgt;
    return cur;
  endfunction

  assign accept    = cmd_valid && cmd_ready;
  assign ms_tick   = (ms_cnt == MsW'(TickDiv - 1));
  assign ramp_tick = ms_tick && (ramp_cnt == RpW'(RampPeriod - 1));

  // Per-op offsets from neutral; undefined ops behave as STOP.
  always_comb begin
    off1 = '0;
    off2 = '0;
    case (cmd_op)
      3'd1:    begin off1 =  FwdS; off2 = -FwdS; end
      3'd2:    begin off1 = -FwdS; off2 =  FwdS; end
      3'd3:    begin off1 = -TrnS; off2 = -TrnS; end
      3'd4:    begin off1 =  TrnS; off2 =  TrnS; end
      default: begin off1 = '0;    off2 = '0;    end
    endcase
  end

  assign tr1  = {{(TgtW-4){trim1[3]}}, trim1};
  assign tr2  = {{(TgtW-4){trim2[3]}}, trim2};
  assign t1_c = sat8(NeuS + off1 + tr1);
  assign t2_c = sat8(NeuS + off2 + tr2);
  assign n1_c = sat8(NeuS + tr1);
  assign n2_c = sat8(NeuS + tr2);

  // Sequencer: prescalers, command latch, ramp/hold/stop state machine.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      ms_cnt    <= '0;
      ramp_cnt  <= '0;
      hold_cnt  <= '0;
      ms_q      <= '0;
      t1_q      <= Neu8;
      t2_q      <= Neu8;
      n1_q      <= Neu8;
      n2_q      <= Neu8;
      speed1    <= Neu8;
      speed2    <= Neu8;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      done <= 1'b0;

      // Prescalers restart on accept so the ramp grid is anchored to the command.
      if (accept) begin
        ms_cnt   <= '0;
        ramp_cnt <= '0;
      end else if (ms_tick) begin
        ms_cnt   <= '0;
        ramp_cnt <= ramp_tick ? '0 : ramp_cnt + RpW'(1);
      end else begin
        ms_cnt   <= ms_cnt + MsW'(1);
      end

      case (state)
        IDLE: begin
          if (accept) begin
            t1_q      <= t1_c;
            t2_q      <= t2_c;
            n1_q      <= n1_c;
            n2_q      <= n2_c;
            ms_q      <= cmd_ms;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= RAMP;
          end
        end
        RAMP: begin
          if (abort) begin
            state <= STOPPING;
          end else if ((speed1 == t1_q) && (speed2 == t2_q)) begin
            hold_cnt <= '0;
            state    <= (ms_q == 16'd0) ? STOPPING : HOLD;
          end else if (ramp_tick) begin
            speed1 <= step_to(speed1, t1_q);
            speed2 <= step_to(speed2, t2_q);
          end
        end
        HOLD: begin
          if (abort || (hold_cnt == ms_q)) begin
            state <= STOPPING;
          end else if (ms_tick) begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        STOPPING: begin
          if ((speed1 == n1_q) && (speed2 == n2_q)) begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            done      <= 1'b1;
            state     <= IDLE;
          end else if (ramp_tick) begin
            speed1 <= step_to(speed1, n1_q);
            speed2 <= step_to(speed2, n2_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drive_ramp_ctrl.sv
// Scoreboard bench for drive_ramp_ctrl with a 10-cycle ms tick. Stimulus pushes
// the expected output events (speed changes and done pulses, with their cycle
// stamps); a monitor pops and compares whenever an output event appears.
module tb_drive_ramp_ctrl;

  localparam int unsigned TD   = 10;
  localparam int unsigned RP   = 2;
  localparam int unsigned TICK = TD * RP;
  localparam int          RS   = 4;
  localparam int          NEU  = 128;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_valid2 = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_ms = 16'd0;
  logic        abort = 1'b0;
  logic        cmd_ready, busy, done, cmd_ready2, busy2, done2;
  logic [7:0]  speed1, speed2, speed1b, speed2b;
`ifdef DRIVE_TRIM_EN
  logic signed [3:0] trim1 = 4'sd0, trim2 = 4'sd0;
`endif

  always #5 Clock = ~Clock;

  drive_ramp_ctrl #(.TickDiv(TD), .RampPeriod(RP), .RampStep(RS), .Neutral(NEU),
                    .FwdSpan(100), .TurnSpan(60)) u_dut (
    .Clock(Clock), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ms(cmd_ms), .abort(abort), .speed1(speed1),
    .speed2(speed2), .busy(busy), .done(done)
`ifdef DRIVE_TRIM_EN
    , .trim1(trim1), .trim2(trim2)
`endif
  );

  // Narrow-span instance: spans that are not a multiple of the ramp step.
  drive_ramp_ctrl #(.TickDiv(TD), .RampPeriod(RP), .RampStep(RS), .Neutral(NEU),
                    .FwdSpan(10), .TurnSpan(60)) u_small (
    .Clock(Clock), .Reset(Reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_ms(cmd_ms), .abort(abort), .speed1(speed1b),
    .speed2(speed2b), .busy(busy2), .done(done2)
`ifdef DRIVE_TRIM_EN
    , .trim1(4'sd0), .trim2(4'sd0)
`endif
  );

  typedef struct {
    int unsigned cyc;
    logic [7:0]  s1;
    logic [7:0]  s2;
    logic        done;
    logic        busy;
    logic        ready;
  } ev_t;

  ev_t         q0[$], q1[$];
  ev_t         obs, expv;
  int          cur1[2], cur2[2];
  int unsigned cyc = 0;
  int          n_checks = 0, n_pass = 0, tmo = 0;
  bit          mon_en = 1'b0, rst_chk = 1'b0, fin_chk = 1'b0;
  logic [7:0]  p1 = 8'd128, p2 = 8'd128, p1b = 8'd128, p2b = 8'd128;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic int step_m(input int c, input int t);
    if (c < t) return ((t - c) > RS) ? c + RS : t;
    if (c > t) return ((c - t) > RS) ? c - RS : t;
    return c;
  endfunction

  task automatic check_ev(input string nm, input ev_t g, input ev_t e, input bit use_cyc);
    n_checks++;
    if ((!use_cyc || g.cyc == e.cyc) && g.s1 == e.s1 && g.s2 == e.s2 &&
        g.done == e.done && g.busy == e.busy && g.ready == e.ready)
      n_pass++;
    else
      $display("FAIL %s: got cyc=%0d spd=(%0d,%0d) done=%0b busy=%0b ready=%0b; expected cyc=%0d spd=(%0d,%0d) done=%0b busy=%0b ready=%0b",
               nm, g.cyc, g.s1, g.s2, g.done, g.busy, g.ready,
               e.cyc, e.s1, e.s2, e.done, e.busy, e.ready);
  endtask

  task automatic push_ev(input int u, input int unsigned c, input int s1, input int s2,
                         input bit d, input bit b, input bit r);
    ev_t e;
    e.cyc = c; e.s1 = 8'(s1); e.s2 = 8'(s2); e.done = d; e.busy = b; e.ready = r;
    if (u == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Expected event schedule of one command accepted at edge a. Ramp steps land
  // on the grid a + k*TICK; cut_at is an abort (or reset, if cut_reset) edge.
  task automatic plan(input int u, input int unsigned a, input int t1, input int t2,
                      input int n1, input int n2, input int unsigned ms,
                      input int unsigned cut_at, input bit cut_reset,
                      output int unsigned idle_at);
    int unsigned k, stop_at;
    int c1, c2;
    bit moved;
    c1 = cur1[u]; c2 = cur2[u]; k = 0;
    while ((c1 != t1 || c2 != t2) && !(cut_at != 0 && !cut_reset && a + TICK * (k + 1) >= cut_at)) begin
      k++;
      c1 = step_m(c1, t1); c2 = step_m(c2, t2);
      push_ev(u, a + TICK * k, c1, c2, 1'b0, 1'b1, 1'b0);
    end
    if (cut_at != 0 && cut_reset) begin
      push_ev(u, cut_at, NEU, NEU, 1'b0, 1'b0, 1'b1);
      cur1[u] = NEU; cur2[u] = NEU; idle_at = cut_at;
      return;
    end
    if (cut_at != 0) stop_at = cut_at;
    else stop_at = a + TICK * k + 1 + TD * ms;
    k = (stop_at - a) / TICK + 1;
    moved = 1'b0;
    while (c1 != n1 || c2 != n2) begin
      c1 = step_m(c1, n1); c2 = step_m(c2, n2);
      push_ev(u, a + TICK * k, c1, c2, 1'b0, 1'b1, 1'b0);
      k++; moved = 1'b1;
    end
    idle_at = moved ? a + TICK * (k - 1) + 1 : stop_at + 1;
    push_ev(u, idle_at, c1, c2, 1'b1, 1'b0, 1'b1);
    cur1[u] = c1; cur2[u] = c2;
  endtask

  // Monitor: every checking comparison happens here.
  always @(negedge Clock) begin
    if (rst_chk) begin
      expv = '{0, 8'd128, 8'd128, 1'b0, 1'b0, 1'b1};
      obs  = '{cyc, speed1, speed2, done, busy, cmd_ready};
      check_ev("reset_state_u0", obs, expv, 1'b0);
      obs  = '{cyc, speed1b, speed2b, done2, busy2, cmd_ready2};
      check_ev("reset_state_u1", obs, expv, 1'b0);
    end
    if (mon_en) begin
      if (speed1 != p1 || speed2 != p2 || done) begin
        obs = '{cyc, speed1, speed2, done, busy, cmd_ready};
        if (q0.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event_u0: got cyc=%0d spd=(%0d,%0d) done=%0b; expected no event",
                   cyc, speed1, speed2, done);
        end else check_ev("event_u0", obs, q0.pop_front(), 1'b1);
      end
      if (speed1b != p1b || speed2b != p2b || done2) begin
        obs = '{cyc, speed1b, speed2b, done2, busy2, cmd_ready2};
        if (q1.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event_u1: got cyc=%0d spd=(%0d,%0d) done=%0b; expected no event",
                   cyc, speed1b, speed2b, done2);
        end else check_ev("event_u1", obs, q1.pop_front(), 1'b1);
      end
    end
    p1 = speed1; p2 = speed2; p1b = speed1b; p2b = speed2b;
    if (fin_chk) begin
      n_checks++;
      if (q0.size() == 0 && q1.size() == 0 && tmo == 0) n_pass++;
      else $display("FAIL drain: got pending u0=%0d u1=%0d timeouts=%0d; expected 0 0 0",
                    q0.size(), q1.size(), tmo);
    end
  end

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge Clock);
  endtask

  task automatic drain(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (q0.size() == 0 && q1.size() == 0) begin ok = 1'b1; break; end
      @(negedge Clock);
    end
    if (!ok) begin tmo++; q0.delete(); q1.delete(); end
    repeat (3) @(negedge Clock);
  endtask

  int unsigned a, a2, idle, idle2;

  initial begin
    cur1[0] = NEU; cur2[0] = NEU; cur1[1] = NEU; cur2[1] = NEU;
    repeat (3) @(posedge Clock);
    rst_chk = 1'b1;
    @(posedge Clock);
    rst_chk = 1'b0;
    mon_en  = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);

    // FWD for 3 ms on both instances (narrow one exercises a partial last step).
    a = cyc + 1;
    plan(0, a, 228, 28, NEU, NEU, 3, 0, 1'b0, idle);
    plan(1, a, 138, 118, NEU, NEU, 3, 0, 1'b0, idle2);
    cmd_op = 3'd1; cmd_ms = 16'd3; cmd_valid = 1'b1; cmd_valid2 = 1'b1;
    @(negedge Clock);
    cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    drain(1500);

    // LEFT with zero hold: straight from ramp-up into stopping.
    a = cyc + 1;
    plan(0, a, 68, 68, NEU, NEU, 0, 0, 1'b0, idle);
    cmd_op = 3'd3; cmd_ms = 16'd0; cmd_valid = 1'b1;
    @(negedge Clock);
    cmd_valid = 1'b0;
    drain(1500);

    // Abort during ramp-up after speed1 reaches 160.
    a = cyc + 1;
    plan(0, a, 228, 28, NEU, NEU, 5, a + 165, 1'b0, idle);
    cmd_op = 3'd1; cmd_ms = 16'd5; cmd_valid = 1'b1;
    @(negedge Clock);
    cmd_valid = 1'b0;
    wait_until(a + 164);
    abort = 1'b1;
    @(negedge Clock);
    abort = 1'b0;
    drain(1500);

    // cmd_valid held across a FWD command; the op-6 command waits for idle.
    a = cyc + 1;
    plan(0, a, 228, 28, NEU, NEU, 3, 0, 1'b0, idle);
    a2 = idle + 1;
    plan(0, a2, NEU, NEU, NEU, NEU, 2, 0, 1'b0, idle2);
    cmd_op = 3'd1; cmd_ms = 16'd3; cmd_valid = 1'b1;
    @(negedge Clock);
    cmd_op = 3'd6; cmd_ms = 16'd2;
    wait_until(a2);
    cmd_valid = 1'b0;
    drain(1500);

    // Reset while holding at (228,28): speeds snap to neutral.
    a = cyc + 1;
    plan(0, a, 228, 28, NEU, NEU, 50, a + 700, 1'b1, idle);
    cmd_op = 3'd1; cmd_ms = 16'd50; cmd_valid = 1'b1;
    @(negedge Clock);
    cmd_valid = 1'b0;
    wait_until(a + 699);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    drain(1500);

`ifdef DRIVE_TRIM_EN
    // Trimmed FWD: targets (225,30), trimmed neutral (125,130).
    trim1 = -4'sd3; trim2 = 4'sd2;
    a = cyc + 1;
    plan(0, a, 225, 30, 125, 130, 0, 0, 1'b0, idle);
    cmd_op = 3'd1; cmd_ms = 16'd0; cmd_valid = 1'b1;
    @(negedge Clock);
    cmd_valid = 1'b0;
    trim1 = 4'sd0; trim2 = 4'sd0;
    drain(1500);
`endif

    @(posedge Clock);
    fin_chk = 1'b1;
    @(posedge Clock);
    fin_chk = 1'b0;
    @(negedge Clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
